// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute/update controller that drives the program counter's nia/branch/im controls.
// Latency: 4 cycles minimum per instruction (FETCH, EXEC start, EXEC done, UPDATE); all outputs registered.
// Backpressure: waits indefinitely in FETCH for imem_ack and in EXEC for ex_done; the counter is held meanwhile.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pc[7:0]                   current counter address (source of the CALL return address)
//   imem_req/imem_ack/imem_data  instruction fetch handshake; opcode [15:12], imm [7:0]
//   ex_start/instr            one-cycle start pulse and latched instruction for the execute unit
//   ex_done/ex_zero           execute completion and zero flag
//   nia/branch/im             counter controls (hold = nia 1, branch 0, im 0)
//   halted                    high once HLT has completed, until reset
//   ras_err                   one-cycle pulse on return-stack overflow (CALL) or underflow (RET)
// Build option: define PC_SEQ_RAS_EN to include the return-address stack. Without it CALL acts as
// JMP, RET acts as an increment and ras_err is constant 0.
module pc_sequencer #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pc,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        ex_start,
  output logic [15:0] instr,
  input  logic        ex_done,
  input  logic        ex_zero,
  output logic        nia,
  output logic        branch,
  output logic [7:0]  im,
  output logic        halted,
  output logic        ras_err
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two in 2..16");
  end

  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BRZ  = 4'h2;
  localparam logic [3:0] OP_CALL = 4'h3;
  localparam logic [3:0] OP_RET  = 4'h4;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t state;

  logic [3:0] op;
  logic [7:0] imm;
  assign op  = instr[15:12];
  assign imm = instr[7:0];

  // Decoded controls for the UPDATE cycle, registered on the EXEC->UPDATE transition.
  logic       d_nia;
  logic       d_branch;
  logic [7:0] d_im;
  logic       d_push;
  logic       d_pop;
  logic       d_err;

  // ex_start is high only in the first EXEC cycle, so it doubles as the "ignore ex_done" flag.
  logic done_ok;
  assign done_ok = ex_done && !ex_start;

`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [7:0]    ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;   // next write slot; top of stack is ras_ptr-1
  logic [PW:0]   ras_cnt;   // valid entries, saturates at RAS_DEPTH
  logic [PW-1:0] ras_top;
  logic          ras_full;
  logic          ras_empty;

  assign ras_top   = ras_ptr - 1'b1;
  assign ras_full  = (ras_cnt == (PW+1)'(RAS_DEPTH));
  assign ras_empty = (ras_cnt == '0);
`else
  // The return address is only needed by the stack.
  logic unused_pc;
  assign unused_pc = ^pc;
  assign ras_err   = 1'b0;
`endif

  always_comb begin
    d_nia    = 1'b0;
    d_branch = 1'b1;
    d_im     = 8'h00;
    d_push   = 1'b0;
    d_pop    = 1'b0;
    d_err    = 1'b0;
    case (op)
      OP_JMP: begin
        d_branch = 1'b0;
        d_im     = imm;
      end
      OP_BRZ: begin
        if (ex_zero) begin
          d_nia = 1'b1;
          d_im  = imm;
        end
      end
      OP_CALL: begin
        d_branch = 1'b0;
        d_im     = imm;
`ifdef PC_SEQ_RAS_EN
        d_push   = 1'b1;
        d_err    = ras_full;
`endif
      end
      OP_RET: begin
`ifdef PC_SEQ_RAS_EN
        // Underflow falls through to a plain increment.
        if (ras_empty) begin
          d_err = 1'b1;
        end else begin
          d_pop    = 1'b1;
          d_branch = 1'b0;
          d_im     = ras_mem[ras_top];
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      imem_req <= 1'b1;
      ex_start <= 1'b0;
      instr    <= 16'h0000;
      nia      <= 1'b1;
      branch   <= 1'b0;
      im       <= 8'h00;
      halted   <= 1'b0;
`ifdef PC_SEQ_RAS_EN
      ras_err  <= 1'b0;
      ras_ptr  <= '0;
      ras_cnt  <= '0;
`endif
    end else begin
      // Hold is the default in every cycle except UPDATE.
      ex_start <= 1'b0;
      nia      <= 1'b1;
      branch   <= 1'b0;
      im       <= 8'h00;
`ifdef PC_SEQ_RAS_EN
      ras_err  <= 1'b0;
`endif
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_data;
            imem_req <= 1'b0;
            ex_start <= 1'b1;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (done_ok) begin
            if (op == OP_HLT) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              nia    <= d_nia;
              branch <= d_branch;
              im     <= d_im;
              state  <= S_UPDATE;
`ifdef PC_SEQ_RAS_EN
              ras_err <= d_err;
              if (d_push) begin
                ras_ptr <= ras_ptr + 1'b1;
                if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
              end else if (d_pop) begin
                ras_ptr <= ras_top;
                ras_cnt <= ras_cnt - 1'b1;
              end
`endif
            end
          end
        end
        S_UPDATE: begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Push writes pc+1 while the counter is still held at the CALL's address.
  always_ff @(posedge clk) begin
    if (!rst && state == S_EXEC && done_ok && op != OP_HLT && d_push) begin
      ras_mem[ras_ptr] <= pc + 8'd1;
    end
  end
`else
  logic unused_dec;
  assign unused_dec = d_push ^ d_pop ^ d_err;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        ex_start;
  logic [15:0] instr;
  logic        ex_done;
  logic        ex_zero;
  logic        nia;
  logic        branch;
  logic [7:0]  im;
  logic        halted;
  logic        ras_err;

  int checks   = 0;
  int failures = 0;

  // Reference stack: back of the queue is the top.
  logic [7:0] ref_stack[$];

  always #5 clk = ~clk;

  pc_sequencer #(.RAS_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ex_start  (ex_start),
    .instr     (instr),
    .ex_done   (ex_done),
    .ex_zero   (ex_zero),
    .nia       (nia),
    .branch    (branch),
    .im        (im),
    .halted    (halted),
    .ras_err   (ras_err)
  );

  // The program counter being controlled; loads every cycle.
  always_ff @(posedge clk) begin
    if (rst) pc <= 8'h00;
    else begin
      case ({nia, branch})
        2'b01:   pc <= pc + 8'd1;
        2'b00:   pc <= im;
        2'b11:   pc <= pc + im;
        default: pc <= pc;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_nia"}, 16'(nia), 16'd1);
    chk({tag, "_branch"}, 16'(branch), 16'd0);
    chk({tag, "_im"}, 16'(im), 16'd0);
  endtask

  // Architectural effect of one instruction: next pc, whether a stack fault occurs.
  task automatic model_step(input logic [3:0] op, input logic [7:0] imm, input bit z,
                            input logic [7:0] cur, output logic [7:0] nxt, output bit err);
    err = 1'b0;
    nxt = cur + 8'd1;
    case (op)
      4'h1: nxt = imm;
      4'h2: if (z) nxt = cur + imm;
      4'h3: begin
        nxt = imm;
`ifdef PC_SEQ_RAS_EN
        if (ref_stack.size() == DEPTH) begin
          err = 1'b1;
          void'(ref_stack.pop_front());
        end
        ref_stack.push_back(cur + 8'd1);
`endif
      end
      4'h4: begin
`ifdef PC_SEQ_RAS_EN
        if (ref_stack.size() == 0) err = 1'b1;
        else nxt = ref_stack.pop_back();
`endif
      end
      default: ;
    endcase
  endtask

  // Expected counter control encoding for a given move.
  task automatic expect_ctl(input logic [3:0] op, input logic [7:0] imm, input bit z,
                            input logic [7:0] cur, input logic [7:0] nxt,
                            output bit e_nia, output bit e_br, output logic [7:0] e_im);
    if (op == 4'h2 && z) begin
      e_nia = 1'b1; e_br = 1'b1; e_im = imm;
    end else if (nxt == cur + 8'd1 && !(op == 4'h1 || op == 4'h3 ||
                 (op == 4'h4 && e_im_is_pop(op)))) begin
      e_nia = 1'b0; e_br = 1'b1; e_im = 8'h00;
    end else begin
      e_nia = 1'b0; e_br = 1'b0; e_im = nxt;
    end
  endtask

  bit last_pop;
  function automatic bit e_im_is_pop(input logic [3:0] op);
    return op == 4'h4 && last_pop;
  endfunction

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; ex_done = 1'b0; ex_zero = 1'b0; imem_data = 16'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_req", 16'(imem_req), 16'd1);
    chk("rst_ex_start", 16'(ex_start), 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk_hold("rst");
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_ras_err", 16'(ras_err), 16'd0);
    chk("rst_pc", 16'(pc), 16'h00);
    ref_stack.delete();
    rst = 1'b0;
  endtask

  // Runs one non-HLT instruction starting from a FETCH cycle at a negedge.
  task automatic do_instr(input logic [3:0] op, input logic [7:0] imm, input bit z,
                          input int ack_dly, input int done_dly, input bit early);
    logic [7:0]  cur, nxt, e_im;
    logic [15:0] word;
    bit          err, e_nia, e_br;
    int          cyc;
    int          pre;
    cur  = pc;
    pre  = ref_stack.size();
    word = {op, 4'($urandom_range(0, 15)), imm};
    model_step(op, imm, z, cur, nxt, err);
`ifdef PC_SEQ_RAS_EN
    last_pop = (op == 4'h4) && (pre != 0);
`else
    last_pop = 1'b0;
`endif
    expect_ctl(op, imm, z, cur, nxt, e_nia, e_br, e_im);
    cyc = 0;
    for (int i = 0; i < ack_dly; i++) begin
      chk("fetch_req", 16'(imem_req), 16'd1);
      chk_hold("fetch");
      imem_ack = 1'b0;
      ex_done  = 1'($urandom_range(0, 1));
      @(negedge clk); cyc++;
    end
    chk("fetch_req", 16'(imem_req), 16'd1);
    imem_ack = 1'b1; imem_data = word; ex_done = 1'($urandom_range(0, 1));
    @(negedge clk); cyc++;
    imem_ack = 1'b0; imem_data = 16'($urandom);
    chk("ex_start_first", 16'(ex_start), 16'd1);
    chk("instr_latched", instr, word);
    chk("exec_req_low", 16'(imem_req), 16'd0);
    chk_hold("exec_first");
    ex_done = early; ex_zero = ~z;
    @(negedge clk); cyc++;
    for (int i = 0; i < done_dly; i++) begin
      chk("ex_start_later", 16'(ex_start), 16'd0);
      chk_hold("exec_wait");
      ex_done  = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk); cyc++;
    end
    chk("ex_start_later", 16'(ex_start), 16'd0);
    chk_hold("exec_wait");
    ex_done = 1'b1; ex_zero = z; imem_ack = 1'b0;
    @(negedge clk); cyc++;
    ex_done = 1'($urandom_range(0, 1)); ex_zero = 1'($urandom_range(0, 1));
    imem_ack = 1'($urandom_range(0, 1));
    chk("upd_nia", 16'(nia), 16'(e_nia));
    chk("upd_branch", 16'(branch), 16'(e_br));
    chk("upd_im", 16'(im), 16'(e_im));
    chk("upd_ras_err", 16'(ras_err), 16'(err));
    chk("upd_ex_start", 16'(ex_start), 16'd0);
    @(negedge clk); cyc++;
    imem_ack = 1'b0; ex_done = 1'b0;
    chk("next_pc", 16'(pc), 16'(nxt));
    chk("next_req", 16'(imem_req), 16'd1);
    chk("next_ras_err", 16'(ras_err), 16'd0);
    chk("instr_cycles", 16'(cyc), 16'(4 + ack_dly + done_dly));
  endtask

  initial begin
    logic [7:0] hold_pc;
    last_pop = 1'b0;
    do_reset();

    // Basic increment with minimum timing.
    do_instr(4'h0, 8'h55, 1'b0, 0, 0, 1'b0);
    // BRZ taken backwards and not taken.
    do_instr(4'h1, 8'h10, 1'b0, 0, 0, 1'b0);
    do_instr(4'h2, 8'hFD, 1'b1, 0, 0, 1'b0);
    chk("brz_taken_pc", 16'(pc), 16'h0D);
    do_instr(4'h1, 8'h10, 1'b0, 0, 0, 1'b0);
    do_instr(4'h2, 8'hFD, 1'b0, 0, 0, 1'b0);
    chk("brz_not_taken_pc", 16'(pc), 16'h11);
    // CALL at 0xFF then RET: return address wraps to 0x00.
    do_instr(4'h1, 8'hFF, 1'b0, 0, 0, 1'b0);
    do_instr(4'h3, 8'h40, 1'b0, 0, 0, 1'b0);
    do_instr(4'h4, 8'h00, 1'b0, 0, 0, 1'b0);
    // Overflow on the fifth CALL, then drain and underflow.
    for (int i = 0; i < 5; i++) do_instr(4'h3, 8'(8'h20 + i), 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) do_instr(4'h4, 8'h00, 1'b0, 0, 0, 1'b0);
    // Slow fetch and early ex_done during the start cycle.
    do_instr(4'h0, 8'h00, 1'b0, 5, 2, 1'b1);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      do_instr(4'($urandom_range(0, 14)), 8'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end

    // HLT: stops with the counter held.
    imem_ack = 1'b1; imem_data = 16'hF000;
    @(negedge clk);
    imem_ack = 1'b0; ex_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ex_done = 1'b0;
    hold_pc = pc;
    for (int i = 0; i < 20; i++) begin
      chk("halt_halted", 16'(halted), 16'd1);
      chk("halt_pc", 16'(pc), 16'(hold_pc));
      chk("halt_req", 16'(imem_req), 16'd0);
      chk_hold("halt");
      imem_ack = 1'($urandom_range(0, 1)); ex_done = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    do_reset();

    // Reset in the middle of EXEC after a CALL left an entry on the stack.
    do_instr(4'h3, 8'h80, 1'b0, 0, 0, 1'b0);
    imem_ack = 1'b1; imem_data = 16'h1077;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mid_ex_start", 16'(ex_start), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 16'(imem_req), 16'd1);
    chk("mid_rst_ex_start", 16'(ex_start), 16'd0);
    chk("mid_rst_instr", instr, 16'h0000);
    chk_hold("mid_rst");
    chk("mid_rst_halted", 16'(halted), 16'd0);
    chk("mid_rst_ras_err", 16'(ras_err), 16'd0);
    chk("mid_rst_pc", 16'(pc), 16'h00);
    rst = 1'b0;
    ref_stack.delete();
    // Stack must now be empty: RET underflows (with the stack) and increments from 0x00.
    do_instr(4'h4, 8'h00, 1'b0, 0, 0, 1'b0);
    chk("post_rst_pc", 16'(pc), 16'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-flow controller for the 8-bit program counter. It fetches each instruction through a request/acknowledge port, hands it to the execute unit, and waits for completion. It then drives the counter's `nia`/`branch`/`im` controls for exactly one cycle so the counter increments, jumps, branches relative, or calls/returns. It sits between instruction memory, the execute unit and the counter, and is the only block that drives the counter's control inputs.

## Interface
- `RAS_DEPTH`, default 4: return-address stack entries, power of two, range 2–16.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high.
- `pc` input 8: current counter address.
- `imem_req` output 1: fetch request at address `pc`.
- `imem_ack` input 1: fetch data valid this cycle.
- `imem_data` input 16: instruction. `[15:12]` opcode, `[7:0]` imm.
- `ex_start` output 1: one-cycle pulse, latched instruction is valid to the execute unit.
- `instr` output 16: latched instruction.
- `ex_done` input 1: execute complete.
- `ex_zero` input 1: zero flag, sampled with `ex_done`.
- `nia` output 1: counter control.
- `branch` output 1: counter control.
- `im` output 8: counter immediate.
- `halted` output 1: sequencer stopped.
- `ras_err` output 1: one-cycle pulse on a stack fault.

## Operation
- Counter control encoding:
  - nia=0, branch=1: increment.
  - nia=0, branch=0: load `im`.
  - nia=1, branch=1: `pc + im`, mod 256, `im` two's complement.
  - nia=1, branch=0: hold.
- The counter loads every cycle, so the sequencer drives hold (nia=1, branch=0, im=0) in every state except UPDATE.
- Opcodes:
  - 0x0 ALU: increment.
  - 0x1 JMP: load imm.
  - 0x2 BRZ: if `ex_zero` then `pc + imm`, else increment.
  - 0x3 CALL: push `pc+1` (8-bit wrap), load imm.
  - 0x4 RET: pop, load the popped value.
  - 0xF HLT: go to HALT.
  - Any other opcode is executed as ALU.
- States:
  - FETCH: `imem_req`=1. On `imem_ack`, latch `imem_data` into `instr` and go to EXEC.
  - EXEC: `ex_start`=1 in the first EXEC cycle only. `ex_done` is ignored in that first cycle. On `ex_done` in a later cycle, latch `ex_zero` and go to UPDATE. HLT skips UPDATE and goes EXEC→HALT on `ex_done`.
  - UPDATE: drive the decoded controls for one cycle, then go to FETCH.
  - HALT: hold controls, `halted`=1. Only `rst` exits.
- Return-address stack:
  - CALL when full: the oldest entry is overwritten (circular pointer), `ras_err` pulses in UPDATE.
  - RET when empty: executes as increment, `ras_err` pulses.
- Reset: state=FETCH, stack empty.
- Reset values of outputs: `imem_req`=1 (first cycle after reset), `ex_start`=0, `instr`=0, nia=1, branch=0, im=0, `halted`=0, `ras_err`=0.
- `rst` mid-instruction discards the latched instruction and stack contents. No UPDATE is issued.
- All outputs are Moore outputs, decoded from the state register and latched registers.

## Timing
- Minimum instruction time is 4 cycles: FETCH with same-cycle ack, EXEC start, EXEC done, UPDATE.
- The counter holds its new value in the cycle after UPDATE, which is the next FETCH cycle.
- `imem_ack` outside FETCH is ignored. `ex_done` outside EXEC is ignored.
- `imem_req` stays high until ack; there is no timeout.
- `ex_zero` is sampled only in the cycle `ex_done` is accepted.

## Configuration
- `PC_SEQ_RAS_EN` defined: the return-address stack is present, and CALL/RET behave as described in Operation.
- `PC_SEQ_RAS_EN` undefined:
  - No stack storage.
  - CALL executes as JMP.
  - RET executes as ALU (increment).
  - `ras_err` is tied to 0.

## Test plan
- Reset, then ALU at pc=0x00 with ack and done each one cycle later → UPDATE drives nia=0/branch=1, pc=0x01, 4 cycles total, `ex_start` exactly one pulse.
- BRZ imm=0xFD at pc=0x10 with `ex_zero`=1 → nia=1/branch=1/im=0xFD, pc=0x0D. Repeat with `ex_zero`=0 → pc=0x11.
- CALL 0x40 at pc=0xFF, then RET → pc=0x40, then pc=0x00 (wrap of the pushed value). With the macro undefined: pc=0x40, then 0x41.
- Five CALLs with `RAS_DEPTH`=4 → `ras_err` pulses on the fifth. RET on an empty stack → increment and `ras_err` pulse.
- `imem_ack` delayed 5 cycles and `ex_done` pulsed during the `ex_start` cycle → controls hold throughout, the early `ex_done` is ignored, and the instruction completes on the later `ex_done`.
- HLT → `halted`=1 and pc stable for 20 cycles. `rst` asserted mid-EXEC → all outputs return to their reset values next cycle, stack is empty, and fetch restarts at pc=0x00.
